async_fifo_wr_arb: RTL and testbench
====================================

Name: async_fifo_wr_arb

Overview:
- Write-side round-robin arbiter that lets NREQ producers share the single push/wdata/full port of the async FIFO.
- Sits entirely in the wclk domain, directly in front of the FIFO write port.
- Grants bounded bursts per requester.
- Owns a one-entry output holding register, so FIFO full back-pressure never loses or duplicates data.

Parameters:
- NREQ, 4, number of requesters (2..8)
- IDWIDTH, 2, width of requester index (ceil log2 NREQ)
- DWIDTH, 8, data width; matches the FIFO DWIDTH
- MAXBURST, 4, max consecutive words granted to one owner (1..2**BCWIDTH-1)
- BCWIDTH, 3, burst counter width

Ports:
- wclk  in  1  write-domain clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request; held high with data stable until granted
- din  in  NREQ*DWIDTH  requester data, requester i at bits [i*DWIDTH +: DWIDTH]
- gnt  out  NREQ  one-hot-or-zero, combinational; data of granted requester captured on this edge
- push  out  1  FIFO push; = out_vld & ~full
- wdata  out  DWIDTH  FIFO write data (holding register)
- full  in  1  FIFO full flag
- owner  out  IDWIDTH  current/last burst owner
- busy  out  1  = (state==BURST) | out_vld
- cnt_sel  in  IDWIDTH  selects statistics counter (optional feature)
- cnt_val  out  16  selected statistics counter value (optional feature)

Behaviour:
- Reset (sync, wclk edge with reset=1):
  - state=IDLE, rr_ptr=0, owner=0, burst_cnt=0, out_vld=0, wdata=0, all stats counters=0.
  - Outputs: gnt=0, push=0, busy=0, cnt_val=0.
  - Any held word is discarded.
  - Reset overrides every other event in the same cycle, including a mid-burst grant.
- Load condition: load = ~out_vld | push. The holding register accepts a new word when empty or draining this cycle.
- State IDLE:
  - If load and any req: winner = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, … mod NREQ.
  - gnt[winner]=1; on the edge: wdata<=din[winner], out_vld<=1, owner<=winner, burst_cnt<=1.
  - If MAXBURST>1, state<=BURST. Otherwise rr_ptr<=winner+1 mod NREQ and stay IDLE.
  - If no load or no req: gnt=0, hold.
- State BURST:
  - Continue: req[owner] & load & burst_cnt<MAXBURST.
    - gnt[owner]=1, capture din[owner], burst_cnt++.
    - If the new count equals MAXBURST: rr_ptr<=owner+1 mod NREQ, state<=IDLE.
  - End: req[owner]=0.
    - gnt=0, rr_ptr<=owner+1 mod NREQ, state<=IDLE.
    - This is one bubble cycle; no re-arbitration in the same cycle.
  - Wait: req[owner]=1 & ~load. gnt=0, stay in BURST, counters hold.
- Output register:
  - When out_vld & ~load (i.e. full=1): wdata and out_vld hold, push=0.
  - Push and refill in the same cycle gives back-to-back pushes at 1 word/cycle.
  - When push and no new grant: out_vld<=0.
- Guarantees:
  - gnt is never asserted for an index with req=0.
  - Never more than one gnt bit set.
  - Max words per owner per tenure = MAXBURST.
  - Starvation-free: any held req is granted within (NREQ-1)*MAXBURST grants to others.
- rr_ptr wraps from NREQ-1 to 0; all index arithmetic is mod NREQ in IDWIDTH bits.

Optional Feature:
- Macro: ASYNC_FIFO_WR_ARB_STATS_EN.
- Defined:
  - One 16-bit grant counter per requester, incremented on each gnt[i] edge.
  - One 16-bit stall counter (indexed by cnt_sel==NREQ when NREQ < 2**IDWIDTH; otherwise not addressable), incremented each cycle with out_vld & full.
  - All counters saturate at 16'hFFFF and clear on reset.
  - cnt_val = registered value of the selected counter, 1-cycle latency from cnt_sel.
- Undefined: counters are not built, cnt_val is tied to 0, cnt_sel is ignored.

Test Plan:
- Single requester: req[2]=1 for 3 words A1,A2,A3, full=0 → gnt[2] pulses 3 consecutive cycles; push high 3 consecutive cycles starting 1 cycle after first gnt; wdata A1,A2,A3; one bubble then IDLE, rr_ptr=3.
- All four req held high, MAXBURST=4 → grant sequence 0,0,0,0,(bubble-free IDLE),1,1,1,1,2…,3…, then wraps to 0; owner tracks.
- Back-pressure: full=1 for 5 cycles while out_vld=1 → push=0, wdata stable, gnt=0 for those cycles; after full drops, push=1 on the next cycle with the same word. Total pushed words equal total granted words.
- Early drop: req[1] deasserts after 2 of 4 words → burst ends, gnt=0 that cycle, next grant to requester 2 (req[2]=1), never requester 1.
- Reset mid-burst: assert reset while owner=3, burst_cnt=2, out_vld=1, full=1 → next cycle push=0, busy=0, gnt=0, rr_ptr=0; after release with all req=1, first grant to requester 0.
- With ASYNC_FIFO_WR_ARB_STATS_EN: after scenario 2 run to 8 grants, cnt_sel=0 → cnt_val=4 one cycle later; cnt_sel=1 → 4. Stall counter equals the number of full=1 cycles with out_vld=1 (scenario 3: 5).

Source files
------------

// File: rtl/async_fifo_wr_arb.sv
// Round-robin write-port arbiter for the async FIFO, wclk domain, with a one-word holding register.
// Optional per-requester grant/stall statistics are built when ASYNC_FIFO_WR_ARB_STATS_EN is defined.
module async_fifo_wr_arb #(
    parameter int NREQ     = 4,
    parameter int IDWIDTH  = 2,
    parameter int DWIDTH   = 8,
    parameter int MAXBURST = 4,
    parameter int BCWIDTH  = 3
) (
    input  logic                   wclk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DWIDTH-1:0] din,
    output logic [NREQ-1:0]        gnt,
    output logic                   push,
    output logic [DWIDTH-1:0]      wdata,
    input  logic                   full,
    output logic [IDWIDTH-1:0]     owner,
    output logic                   busy,
    input  logic [IDWIDTH-1:0]     cnt_sel,
    output logic [15:0]            cnt_val
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]         state;
    logic [IDWIDTH-1:0] rr_ptr;
    logic [IDWIDTH-1:0] winner;
    logic [IDWIDTH-1:0] sel;
    logic [BCWIDTH-1:0] burst_cnt;
    logic [BCWIDTH-1:0] burst_nxt;
    logic               out_vld;
    logic               load;
    logic               found;
    logic               grant_en;
    logic [DWIDTH-1:0]  din_arr [NREQ];

    function automatic logic [IDWIDTH-1:0] next_idx(input logic [IDWIDTH-1:0] i);
        return (i == IDWIDTH'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    for (genvar g = 0; g < NREQ; g++) begin : g_din
        assign din_arr[g] = din[g*DWIDTH +: DWIDTH];
    end

    // Reset suppresses both handshakes so a word in flight is dropped rather than pushed.
    assign push      = out_vld & ~full & ~reset;
    assign load      = ~out_vld | push;
    assign busy      = (state == ST_BURST) | out_vld;
    assign burst_nxt = burst_cnt + 1'b1;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[(int'(rr_ptr) + k) % NREQ]) begin
                found  = 1'b1;
                winner = IDWIDTH'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        grant_en = 1'b0;
        sel      = winner;
        if (!reset) begin
            if (state == ST_IDLE) begin
                grant_en = load & found;
            end else begin
                sel      = owner;
                grant_en = req[owner] & load & (burst_cnt < BCWIDTH'(MAXBURST));
            end
        end
        gnt = grant_en ? (NREQ'(1) << sel) : '0;
    end

    always_ff @(posedge wclk) begin
        if (reset) begin
            state     <= ST_IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
            out_vld   <= 1'b0;
            wdata     <= '0;
        end else begin
            if (grant_en) begin
                wdata   <= din_arr[sel];
                out_vld <= 1'b1;
                owner   <= sel;
            end else if (push) begin
                out_vld <= 1'b0;
            end
            if (state == ST_IDLE) begin
                if (grant_en) begin
                    burst_cnt <= BCWIDTH'(1);
                    if (MAXBURST > 1) state  <= ST_BURST;
                    else              rr_ptr <= next_idx(winner);
                end
            end else if (grant_en) begin
                burst_cnt <= burst_nxt;
                if (burst_nxt == BCWIDTH'(MAXBURST)) begin
                    rr_ptr <= next_idx(owner);
                    state  <= ST_IDLE;
                end
            end else if (!req[owner]) begin
                // Owner dropped: one bubble cycle, re-arbitration starts next cycle.
                rr_ptr <= next_idx(owner);
                state  <= ST_IDLE;
            end
        end
    end

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
    logic [15:0] gnt_cnt [NREQ];
    logic [15:0] stall_cnt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge wclk) begin
        if (reset) begin
            for (int i = 0; i < NREQ; i++) gnt_cnt[i] <= '0;
            stall_cnt <= '0;
            cnt_val   <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i]) gnt_cnt[i] <= sat_inc(gnt_cnt[i]);
            end
            if (out_vld && full) stall_cnt <= sat_inc(stall_cnt);
            if (int'(cnt_sel) < NREQ)       cnt_val <= gnt_cnt[cnt_sel];
            else if (int'(cnt_sel) == NREQ) cnt_val <= stall_cnt;
            else                            cnt_val <= '0;
        end
    end
`else
    logic unused_cnt_sel;
    assign unused_cnt_sel = ^cnt_sel;
    assign cnt_val        = '0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_arb.sv
// Randomized bench for async_fifo_wr_arb against a transaction-level model of the arbiter and holding register.
module tb_async_fifo_wr_arb;
    localparam int NREQ     = 4;
    localparam int IDWIDTH  = 2;
    localparam int DWIDTH   = 8;
    localparam int MAXBURST = 4;
    localparam int BCWIDTH  = 3;

    logic                   wclk = 1'b0;
    logic                   reset;
    logic [NREQ-1:0]        req;
    logic [NREQ*DWIDTH-1:0] din;
    logic [NREQ-1:0]        gnt;
    logic                   push;
    logic [DWIDTH-1:0]      wdata;
    logic                   full;
    logic [IDWIDTH-1:0]     owner;
    logic                   busy;
    logic [IDWIDTH-1:0]     cnt_sel;
    logic [15:0]            cnt_val;

    async_fifo_wr_arb #(
        .NREQ(NREQ), .IDWIDTH(IDWIDTH), .DWIDTH(DWIDTH), .MAXBURST(MAXBURST), .BCWIDTH(BCWIDTH)
    ) dut (
        .wclk(wclk), .reset(reset), .req(req), .din(din), .gnt(gnt), .push(push),
        .wdata(wdata), .full(full), .owner(owner), .busy(busy), .cnt_sel(cnt_sel), .cnt_val(cnt_val)
    );

    always #5 wclk = ~wclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Requester side: words still to send and the word currently presented.
    int         rem [NREQ];
    logic [7:0] dat [NREQ];

    // Model state: tenure in progress, its owner and length, next priority, held words.
    bit         m_in_burst;
    int         m_own;
    int         m_ten;
    int         m_ptr;
    int         m_last_owner;
    logic [7:0] hq [$];
    int         m_gcnt [NREQ];
    int         m_stall;
    int         granted;
    int         pushed;
    bit         rec;
    int         seq [$];

    task automatic model_reset();
        m_in_burst = 0; m_own = 0; m_ten = 0; m_ptr = 0; m_last_owner = 0;
        hq.delete();
        for (int i = 0; i < NREQ; i++) m_gcnt[i] = 0;
        m_stall = 0; granted = 0; pushed = 0;
    endtask

    task automatic step(input bit do_reset, input int full_pct, input int arrive_pct);
        int  gi;
        bit  hv, e_push, can, e_busy;
        logic [NREQ-1:0] e_gnt;
        reset = do_reset;
        full  = ($urandom_range(99) < full_pct);
        for (int i = 0; i < NREQ; i++) begin
            req[i]                = (rem[i] > 0);
            din[i*DWIDTH +: DWIDTH] = dat[i];
        end
        @(negedge wclk);
        if (do_reset) begin
            check_val("gnt_in_reset", gnt, 0);
            check_val("push_in_reset", push, 0);
            model_reset();
        end else begin
            gi     = -1;
            hv     = (hq.size() > 0);
            e_push = hv && !full;
            can    = !hv || e_push;
            e_busy = m_in_burst || hv;
            if (!m_in_burst) begin
                if (can) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (gi < 0 && req[(m_ptr + k) % NREQ]) gi = (m_ptr + k) % NREQ;
                    end
                end
            end else if (!req[m_own]) begin
                m_in_burst = 0;
                m_ptr      = (m_own + 1) % NREQ;
            end else if (can) begin
                gi = m_own;
            end
            e_gnt = (gi >= 0) ? (NREQ'(1) << gi) : '0;
            check_val("gnt", gnt, e_gnt);
            check_val("push", push, e_push);
            check_val("busy", busy, e_busy);
            check_val("owner", owner, m_last_owner);
            if (hv) check_val("wdata", wdata, hq[0]);
            if (e_push) begin
                void'(hq.pop_front());
                pushed++;
            end
            if (hv && full) m_stall++;
            if (gi >= 0) begin
                hq.push_back(dat[gi]);
                granted++;
                m_gcnt[gi]++;
                if (rec) seq.push_back(gi);
                if (!m_in_burst) begin
                    m_own = gi;
                    m_ten = 0;
                end
                m_ten++;
                m_last_owner = gi;
                if (m_ten == MAXBURST) begin
                    m_in_burst = 0;
                    m_ptr      = (gi + 1) % NREQ;
                end else begin
                    m_in_burst = 1;
                end
                rem[gi]--;
                dat[gi] = 8'($urandom);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rem[i] == 0 && $urandom_range(99) < arrive_pct) begin
                rem[i] = 1 + $urandom_range(5);
                dat[i] = 8'($urandom);
            end
        end
        @(posedge wclk);
        #1;
    endtask

    initial begin
        int fp;
        bit drained;
        reset = 1'b1; full = 1'b0; req = '0; din = '0; cnt_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            rem[i] = 0;
            dat[i] = 8'($urandom);
        end
        rec = 0;
        model_reset();
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        check_val("cnt_val_after_reset", cnt_val, 0);

        // All requesters held: bursts of MAXBURST rotate 0,1,2,3.
        for (int i = 0; i < NREQ; i++) rem[i] = 20;
        rec = 1;
        for (int c = 0; c < 24; c++) step(0, 0, 0);
        rec = 0;
        check_val("seq_len", (seq.size() >= 16), 1);
        for (int j = 0; j < 16 && j < seq.size(); j++) check_val("rr_seq", seq[j], j / MAXBURST);

        // Randomized traffic with varying back-pressure and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            fp = (c / 500) * 15;
            step($urandom_range(299) == 0, fp, 20);
        end

        // Drain: stop arrivals, release full, bounded wait for quiescence.
        drained = 0;
        for (int c = 0; c < 300 && !drained; c++) begin
            step(0, 0, 0);
            drained = (hq.size() == 0) && !m_in_burst;
            for (int i = 0; i < NREQ; i++) if (rem[i] != 0) drained = 0;
        end
        check_val("drain_timeout", drained, 1);
        check_val("pushed_eq_granted", pushed, granted);

`ifdef ASYNC_FIFO_WR_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++) begin
            cnt_sel = IDWIDTH'(i);
            step(0, 0, 0);
            check_val("grant_count", cnt_val, m_gcnt[i]);
        end
        if (NREQ < (1 << IDWIDTH)) begin
            cnt_sel = IDWIDTH'(NREQ);
            step(0, 0, 0);
            check_val("stall_count", cnt_val, m_stall);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
